// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared definitions for the seven-segment display blocks.
//
// Holds the active-low segment codes for hex digits 0-F and the all-off
// constants, so any display block can import them and stay consistent.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/seg_scan_hex7seg.sv
// hex7seg: combinational hex-to-seven-segment decoder.
//
// Ports:
//   hex  in  4  hex digit value
//   seg  out 7  segments {g,f,e,d,c,b,a}, active-low
module hex7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (hex)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed seven-segment display scanner.
//
// clk_slow is treated as data: it is synchronized, edge-detected, and each
// rising edge ("tick") advances the display by one digit slot. A whole frame
// (data + dp_en) is latched on the tick that wraps the digit index from 3 to
// 0, so the displayed digits never mix two frames.
//
// Ports:
//   clk          in  1   system clock
//   rst          in  1   synchronous active-high reset
//   clk_slow     in  1   slow scan strobe, sampled as data
//   data         in  16  four hex digits, digit k = data[4k+3:4k]
//   dp_en        in  4   decimal point enable per digit
//   blank        in  1   1 = all digits off for this slot
//   an           out 4   digit anodes, active-low
//   seg          out 7   segments {g,f,e,d,c,b,a}, active-low
//   dp           out 1   decimal point, active-low
//   frame_start  out 1   one-cycle pulse after a frame is latched
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter bit LZB         = 1'b0,
  parameter int SYNC_STAGES = 2     // legal range 2..3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_slow,
  input  logic [15:0] data,
  input  logic [3:0]  dp_en,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick;

  digit_idx_t  idx_q;
  digit_idx_t  idx_n;
  logic [15:0] frame_q;
  logic [3:0]  frame_dp_q;
  logic [15:0] frame_n;
  logic [3:0]  frame_dp_n;
  logic        latch;
  logic [3:0]  digit;
  logic [6:0]  dec_seg;
  logic [3:0]  lead_zero;
  logic        lz_blank;

  // Synchronizer chain plus one history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_slow};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick  = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign idx_n = idx_q + 2'd1;
  assign latch = tick && (idx_q == 2'd3);

  // Digit 0 of a new frame must already see the freshly latched values,
  // so the output path looks through the latch mux rather than frame_q.
  assign frame_n    = latch ? data  : frame_q;
  assign frame_dp_n = latch ? dp_en : frame_dp_q;
  assign digit      = frame_n[{idx_n, 2'b00} +: 4];

  // lead_zero[k]: digit k and every higher digit are 0 with dp off.
  always_comb begin
    logic run;
    lead_zero = '0;
    run       = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run          = run & (frame_n[4*k +: 4] == 4'h0) & ~frame_dp_n[k];
      lead_zero[k] = run;
    end
  end

  // Digit 0 always shows, even when the whole frame is zero.
  assign lz_blank = LZB && (idx_n != 2'd0) && lead_zero[idx_n];

  hex7seg u_hex7seg (
    .hex (digit),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      frame_q     <= '0;
      frame_dp_q  <= '0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= latch;
      if (tick) begin
        idx_q      <= idx_n;
        frame_q    <= frame_n;
        frame_dp_q <= frame_dp_n;
        if (blank || lz_blank) begin
          an  <= AN_OFF;
          seg <= SEG_OFF;
          dp  <= 1'b1;
        end else begin
          an  <= ~(4'b0001 << idx_n);
          seg <= dec_seg;
          dp  <= ~frame_dp_n[idx_n];
        end
      end
    end
  end

endmodule
